// File: rtl/sm_pkg.sv
// sm_pkg: shared definitions for the stack-machine operand stack.
//   op_e     - engine operation encodings (NOP/PUSH/POP/illegal)
//   state_e  - arbiter ownership state
//   SM_*     - default datapath sizing, shared with the SM datapath
package sm_pkg;

  localparam int SM_WIDTH    = 20;
  localparam int SM_DEPTH    = 8;
  localparam int SM_LOCK_MAX = 8;

  typedef enum logic [1:0] {
    OP_NOP  = 2'b00,
    OP_PUSH = 2'b01,
    OP_POP  = 2'b10,
    OP_ILL  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ARB    = 2'b00,
    LOCK_A = 2'b01,
    LOCK_B = 2'b10
  } state_e;

endpackage

// File: rtl/sm_stack_arbiter_if.sv
// sm_stack_arbiter_if: one engine's request/response channel to the stack.
//   req/lock/op/wdata  - engine -> arbiter (operation request)
//   gnt                - arbiter -> engine, combinational ready
//   ack/err/rdata      - arbiter -> engine, registered response
// master: instruction engine side; slave: arbiter side.
interface sm_stack_arbiter_if #(
  parameter int WIDTH = sm_pkg::SM_WIDTH
);
  logic             req;
  logic             lock;
  logic [1:0]       op;
  logic [WIDTH-1:0] wdata;
  logic             gnt;
  logic             ack;
  logic             err;
  logic [WIDTH-1:0] rdata;

  modport master (output req, lock, op, wdata, input gnt, ack, err, rdata);
  modport slave  (input req, lock, op, wdata, output gnt, ack, err, rdata);
endinterface

// File: rtl/sm_stack_core.sv
// sm_stack_core: LIFO storage and occupancy counter, no arbitration.
//   push/pop  - strobes (ignored when full/empty respectively)
//   wdata     - push data
//   rdata     - current top of stack (combinational, valid when !empty)
//   count     - occupancy; full/empty decode it
module sm_stack_core
  import sm_pkg::*;
#(
  parameter int WIDTH = SM_WIDTH,
  parameter int DEPTH = SM_DEPTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           rdata,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);
  localparam int CW = $clog2(DEPTH+1);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [CW-1:0]    top_ptr;

  // count-1 wraps when empty; rdata is then garbage but never consumed.
  assign top_ptr = count - CW'(1);
  assign rdata   = mem[top_ptr[AW-1:0]];
  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);

  always_ff @(posedge clk) begin
    if (rst)                count <= '0;
    else if (push && !full) count <= count + CW'(1);
    else if (pop && !empty) count <= count - CW'(1);
  end

  // Storage is intentionally not reset.
  always_ff @(posedge clk) begin
    if (push && !full) mem[count[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/sm_stack_arbiter.sv
// sm_stack_arbiter: two-port round-robin arbiter with optional ownership lock
// in front of a shared LIFO operand stack.
//   clk, rst   - clock, synchronous active-high reset
//   a, b       - engine channels (sm_stack_arbiter_if.slave)
//   lock_to    - one-cycle pulse after a lock timeout forced release
//   count      - stack occupancy; full/empty decode it
module sm_stack_arbiter
  import sm_pkg::*;
#(
  parameter int WIDTH    = SM_WIDTH,
  parameter int DEPTH    = SM_DEPTH,
  parameter int LOCK_MAX = SM_LOCK_MAX
) (
  input  logic                       clk,
  input  logic                       rst,
  sm_stack_arbiter_if.slave          a,
  sm_stack_arbiter_if.slave          b,
  output logic                       lock_to,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);
  localparam int LCW = $clog2(LOCK_MAX+1);

  // Index 0 = port A, index 1 = port B.
  logic [1:0]            req, lock, gnt, xfer;
  logic [1:0][1:0]       op;
  logic [1:0][WIDTH-1:0] wdata;

  state_e         state;
  logic           rr;        // 0: A has priority, 1: B has priority
  logic [LCW-1:0] lock_cnt;

  logic [1:0]            ack_q, err_q;
  logic [1:0][WIDTH-1:0] rdata_q;

  logic             sel, any, sel_lock, owner, tmo, push, pop, op_err;
  op_e              sel_op;
  logic [WIDTH-1:0] top;

  assign req   = {b.req,   a.req};
  assign lock  = {b.lock,  a.lock};
  assign op    = {b.op,    a.op};
  assign wdata = {b.wdata, a.wdata};

  assign a.gnt   = gnt[0];
  assign b.gnt   = gnt[1];
  assign a.ack   = ack_q[0];
  assign b.ack   = ack_q[1];
  assign a.err   = err_q[0];
  assign b.err   = err_q[1];
  assign a.rdata = rdata_q[0];
  assign b.rdata = rdata_q[1];

  assign owner = (state == LOCK_B);
  assign tmo   = (state != ARB) && (lock_cnt == LCW'(LOCK_MAX));

  always_comb begin
    gnt = '0;
    if (!rst) begin
      case (state)
        ARB: begin
          if (req[0] && (!req[1] || !rr)) gnt[0] = 1'b1;
          else if (req[1])                gnt[1] = 1'b1;
        end
        LOCK_A:  gnt[0] = !tmo;
        LOCK_B:  gnt[1] = !tmo;
        default: gnt    = '0;
      endcase
    end
  end

  // gnt is one-hot at most, so a single mux selects the transferring port.
  assign xfer     = req & gnt;
  assign any      = |xfer;
  assign sel      = xfer[1];
  assign sel_op   = op_e'(op[sel]);
  assign sel_lock = lock[sel];

  assign push   = any && (sel_op == OP_PUSH) && !full;
  assign pop    = any && (sel_op == OP_POP)  && !empty;
  assign op_err = ((sel_op == OP_PUSH) && full)  ||
                  ((sel_op == OP_POP)  && empty) ||
                  (sel_op == OP_ILL);

  sm_stack_core #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_core (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata (wdata[sel]),
    .rdata (top),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ARB;
      rr       <= 1'b0;
      lock_cnt <= '0;
      ack_q    <= '0;
      err_q    <= '0;
      rdata_q  <= '0;
      lock_to  <= 1'b0;
    end else begin
      ack_q   <= xfer;
      err_q   <= xfer & {2{op_err}};
      lock_to <= tmo;
      for (int i = 0; i < 2; i++)
        rdata_q[i] <= (xfer[i] && pop) ? top : '0;

      case (state)
        ARB: begin
          if (any) begin
            rr <= ~sel;
            if (sel_lock) begin
              state    <= sel ? LOCK_B : LOCK_A;
              lock_cnt <= '0;
            end
          end
        end
        LOCK_A, LOCK_B: begin
          lock_cnt <= lock_cnt + LCW'(1);
          // Timeout wins over a voluntary release in the same cycle so the
          // lock_to pulse is never lost.
          if (tmo || (!lock[owner] && (xfer[owner] || !req[owner]))) begin
            state    <= ARB;
            rr       <= ~owner;
            lock_cnt <= '0;
          end
        end
        default: state <= ARB;
      endcase
    end
  end

endmodule

// File: tb/tb_sm_stack_arbiter.sv
// tb_sm_stack_arbiter: directed test of sm_stack_arbiter with hand-computed
// expectations. Inputs change 1 time unit after posedge; gnt is sampled one
// further unit later, registered outputs right after the step.
module tb_sm_stack_arbiter;
  import sm_pkg::*;

  localparam int W = 20;

  logic       clk = 1'b0;
  logic       rst;
  logic       lock_to;
  logic [3:0] count;
  logic       full, empty;

  int n_chk = 0;
  int n_err = 0;

  sm_stack_arbiter_if #(.WIDTH(W)) ai ();
  sm_stack_arbiter_if #(.WIDTH(W)) bi ();

  sm_stack_arbiter #(.WIDTH(W), .DEPTH(8), .LOCK_MAX(8)) dut (
    .clk     (clk),
    .rst     (rst),
    .a       (ai),
    .b       (bi),
    .lock_to (lock_to),
    .count   (count),
    .full    (full),
    .empty   (empty)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drv_a(input logic r, input logic l, input logic [1:0] o, input logic [W-1:0] d);
    ai.req = r; ai.lock = l; ai.op = o; ai.wdata = d;
  endtask

  task automatic drv_b(input logic r, input logic l, input logic [1:0] o, input logic [W-1:0] d);
    bi.req = r; bi.lock = l; bi.op = o; bi.wdata = d;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // ---- reset: gnt forced low, state cleared
    rst = 1'b1;
    drv_a(1, 0, OP_PUSH, 20'h5);
    drv_b(1, 0, OP_PUSH, 20'h6);
    #1;
    chk("rst_gnt_a", 32'(ai.gnt), 0);
    chk("rst_gnt_b", 32'(bi.gnt), 0);
    step();
    chk("rst_count", 32'(count), 0);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_full",  32'(full), 0);
    chk("rst_ack_a", 32'(ai.ack), 0);
    chk("rst_lockto", 32'(lock_to), 0);
    rst = 1'b0;
    drv_a(0, 0, OP_NOP, 0);
    drv_b(0, 0, OP_NOP, 0);
    step();

    // ---- 1: basic push/pop
    drv_a(1, 0, OP_PUSH, 20'h00005);
    #1 chk("t1_gnt_a", 32'(ai.gnt), 1);
    step();
    chk("t1_ack_a", 32'(ai.ack), 1);
    chk("t1_cnt1", 32'(count), 1);
    drv_a(1, 0, OP_PUSH, 20'h00003);
    step();
    chk("t1_cnt2", 32'(count), 2);
    drv_a(0, 0, OP_NOP, 0);
    drv_b(1, 0, OP_POP, 0);
    #1 chk("t1_gnt_b", 32'(bi.gnt), 1);
    step();
    chk("t1_pop1_ack", 32'(bi.ack), 1);
    chk("t1_pop1_data", 32'(bi.rdata), 32'h3);
    chk("t1_pop1_err", 32'(bi.err), 0);
    step();
    chk("t1_pop2_data", 32'(bi.rdata), 32'h5);
    chk("t1_pop2_err", 32'(bi.err), 0);
    chk("t1_empty", 32'(empty), 1);
    drv_b(0, 0, OP_NOP, 0);
    step();
    chk("t1_idle_ack", 32'(bi.ack), 0);

    // ---- 2: round-robin, rr currently points at A
    drv_a(1, 0, OP_PUSH, 20'h1);
    drv_b(1, 0, OP_PUSH, 20'h2);
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("t2_rr_a", 32'(ai.gnt), 32'((i % 2) == 0));
      chk("t2_rr_b", 32'(bi.gnt), 32'((i % 2) == 1));
      step();
    end
    drv_a(0, 0, OP_NOP, 0);
    drv_b(0, 0, OP_NOP, 0);
    chk("t2_cnt", 32'(count), 4);
    drv_a(1, 0, OP_POP, 0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("t2_pop", 32'(ai.rdata), 32'((i % 2) == 0 ? 2 : 1));
    end
    drv_a(0, 0, OP_NOP, 0);

    // ---- 3: atomic pop-pop-push; setup via B leaves rr on A
    drv_b(1, 0, OP_PUSH, 20'h7);
    step();
    drv_b(1, 0, OP_PUSH, 20'h4);
    step();
    chk("t3_cnt_pre", 32'(count), 2);
    drv_b(1, 0, OP_PUSH, 20'h9);
    drv_a(1, 1, OP_POP, 0);
    #1 chk("t3_gnt_b0", 32'(bi.gnt), 0);
    step();
    chk("t3_pop1", 32'(ai.rdata), 32'h4);
    drv_a(1, 1, OP_POP, 0);
    #1 chk("t3_gnt_b1", 32'(bi.gnt), 0);
    step();
    chk("t3_pop2", 32'(ai.rdata), 32'h7);
    drv_a(1, 0, OP_PUSH, 20'h0000B);
    #1 chk("t3_gnt_b2", 32'(bi.gnt), 0);
    step();
    chk("t3_cnt_mid", 32'(count), 1);
    drv_a(0, 0, OP_NOP, 0);
    #1 chk("t3_gnt_b3", 32'(bi.gnt), 1);
    step();
    chk("t3_ack_b", 32'(bi.ack), 1);
    chk("t3_cnt", 32'(count), 2);
    drv_b(0, 0, OP_NOP, 0);
    drv_a(1, 0, OP_POP, 0);
    step();
    chk("t3_top", 32'(ai.rdata), 32'h9);
    step();
    chk("t3_bot", 32'(ai.rdata), 32'hB);
    drv_a(0, 0, OP_NOP, 0);

    // ---- 4: full / empty errors, illegal op, NOP
    for (int i = 0; i < 8; i++) begin
      drv_a(1, 0, OP_PUSH, W'(32'h10 + i));
      step();
    end
    chk("t4_cnt8", 32'(count), 8);
    chk("t4_full", 32'(full), 1);
    drv_a(1, 0, OP_PUSH, 20'hFFFFF);
    step();
    chk("t4_ovf_ack", 32'(ai.ack), 1);
    chk("t4_ovf_err", 32'(ai.err), 1);
    chk("t4_ovf_cnt", 32'(count), 8);
    drv_a(1, 0, OP_POP, 0);
    for (int i = 0; i < 8; i++) begin
      step();
      chk("t4_pop", 32'(ai.rdata), 32'h17 - 32'(i));
    end
    chk("t4_empty", 32'(empty), 1);
    step();
    chk("t4_unf_err", 32'(ai.err), 1);
    chk("t4_unf_data", 32'(ai.rdata), 0);
    drv_a(1, 0, OP_ILL, 20'h12345);
    step();
    chk("t4_ill_err", 32'(ai.err), 1);
    chk("t4_ill_cnt", 32'(count), 0);
    drv_a(1, 0, OP_NOP, 0);
    step();
    chk("t4_nop_ack", 32'(ai.ack), 1);
    chk("t4_nop_err", 32'(ai.err), 0);
    drv_a(0, 0, OP_NOP, 0);

    // ---- 5: lock timeout; one B NOP first so rr points at A
    drv_b(1, 0, OP_NOP, 0);
    step();
    drv_a(1, 1, OP_NOP, 0);
    drv_b(1, 0, OP_PUSH, 20'h55);
    #1;
    chk("t5_entry_a", 32'(ai.gnt), 1);
    chk("t5_entry_b", 32'(bi.gnt), 0);
    step();
    for (int i = 0; i < 9; i++) begin
      #1;
      chk("t5_hold_b", 32'(bi.gnt), 0);
      chk("t5_hold_a", 32'(ai.gnt), 32'(i < 8));
      chk("t5_no_to", 32'(lock_to), 0);
      step();
    end
    chk("t5_lockto", 32'(lock_to), 1);
    #1;
    chk("t5_after_b", 32'(bi.gnt), 1);
    chk("t5_after_a", 32'(ai.gnt), 0);
    step();
    chk("t5_ack_b", 32'(bi.ack), 1);
    chk("t5_cnt", 32'(count), 1);
    chk("t5_lockto_off", 32'(lock_to), 0);
    drv_a(0, 0, OP_NOP, 0);
    drv_b(0, 0, OP_NOP, 0);

    // ---- 6: reset in the middle of a lock
    drv_a(1, 0, OP_PUSH, 20'h1);
    step();
    drv_a(1, 1, OP_PUSH, 20'h2);
    step();
    chk("t6_cnt3", 32'(count), 3);
    drv_a(1, 1, OP_PUSH, 20'h3);
    rst = 1'b1;
    #1 chk("t6_rst_gnt", 32'(ai.gnt), 0);
    step();
    chk("t6_cnt", 32'(count), 0);
    chk("t6_empty", 32'(empty), 1);
    chk("t6_ack_a", 32'(ai.ack), 0);
    chk("t6_ack_b", 32'(bi.ack), 0);
    chk("t6_lockto", 32'(lock_to), 0);
    rst = 1'b0;
    drv_a(0, 0, OP_NOP, 0);
    drv_b(1, 0, OP_PUSH, 20'h77);
    #1 chk("t6_gnt_b", 32'(bi.gnt), 1);
    step();
    chk("t6_ack_b2", 32'(bi.ack), 1);
    chk("t6_cnt1", 32'(count), 1);
    drv_b(0, 0, OP_NOP, 0);
    step();
    chk("t6_no_to", 32'(lock_to), 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/sm_stack_arbiter.md
# sm_stack_arbiter

Two-port arbiter and sequencer for a shared 20-bit LIFO operand stack in the stack-machine datapath. It lets two instruction engines (port A, port B) issue push/pop operations to one stack. Selection is round-robin, and an optional lock lets one engine hold ownership so its ADD/SUB/MUL pop-pop-push runs atomically. A timeout stops a stuck owner from starving the other port.

## Interface
- `WIDTH`, default 20, stack word width.
- `DEPTH`, default 8, stack entries.
- `LOCK_MAX`, default 8, maximum cycles one port may hold the lock.
- `clk` input 1: rising-edge clock.
- `rst` input 1: synchronous, active-high reset.
- `a_req` / `b_req` input 1: operation valid.
- `a_lock` / `b_lock` input 1: request (or keep) exclusive ownership with this operation.
- `a_op` / `b_op` input 2: 00 NOP, 01 PUSH, 10 POP, 11 illegal.
- `a_wdata` / `b_wdata` input WIDTH: push data.
- `a_gnt` / `b_gnt` output 1: combinational ready; a transfer occurs at the edge where req && gnt.
- `a_ack` / `b_ack` output 1: registered, one-cycle pulse in the cycle after the transfer.
- `a_err` / `b_err` output 1: registered, qualifies ack.
- `a_rdata` / `b_rdata` output WIDTH: registered pop result, valid with ack.
- `lock_to` output 1: registered one-cycle pulse on lock timeout.
- `count` output $clog2(DEPTH+1): current occupancy.
- `full` / `empty` output 1: count==DEPTH / count==0.

## Operation
- **FSM states**
  - ARB: no owner.
  - LOCKED(owner ∈ {A,B}).
- **ARB**
  - If exactly one req is high, that port is granted.
  - If both are high, the port named by the priority pointer `rr` is granted. `rr` resets to A.
  - After any transfer in ARB, `rr` points to the other port.
  - A transfer with lock=1 moves the FSM to LOCKED(that port) and clears `lock_cnt` to 0.
- **LOCKED**
  - Only the owner's gnt can be 1. The other port's gnt is 0.
  - The FSM returns to ARB after:
    - an owner transfer with lock=0, or
    - any cycle in which the owner has req=0 and lock=0.
  - On release, `rr` points to the non-owner.
- **Lock timeout**
  - `lock_cnt` increments every cycle spent in LOCKED.
  - In the cycle where `lock_cnt == LOCK_MAX`, both gnts are 0 and the next state is ARB with `rr` set to the non-owner.
  - `lock_to` is 1 in the following cycle.
- **Operation effects**, applied at the transfer edge:
  - PUSH, not full: mem[count] ← wdata; count+1; err=0.
  - PUSH, full: no write; count unchanged; err=1.
  - POP, not empty: rdata ← mem[count-1]; count-1; err=0.
  - POP, empty: rdata=0; err=1.
  - NOP: ack with err=0 and rdata=0.
  - Illegal op (11): ack with err=1, rdata=0, no state change.
- rdata is 0 whenever the op was not a successful POP.
- Only one transfer can happen per cycle, so simultaneous push/pop never occurs.

## Timing
- Throughput is 1 op/cycle. A port may keep req high to issue back-to-back ops. Each edge with req && gnt is a separate transfer.
- gnt depends on the current-cycle req, lock, state, `rr` and `lock_cnt`. It does not depend on ack.
- Latency is 1 cycle:
  - ack, err and rdata appear in the cycle after the transfer edge.
  - count, full and empty are updated at that same edge.
- A pop followed immediately by a push from the other port, in consecutive cycles, sees the updated count.
- rst overrides everything, including a transfer in the same cycle:
  - During rst, all gnt outputs are forced 0.
  - After the edge: state=ARB, `rr`=A, `lock_cnt`=0, count=0, empty=1, full=0.
  - ack, err, rdata and lock_to are all 0.
  - mem contents are not cleared and are don't-care.
- A reset in the middle of a locked sequence abandons the lock with no lock_to pulse.

## Structure
- Package `sm_pkg`:
  - op encodings OP_NOP, OP_PUSH, OP_POP, OP_ILL;
  - FSM state enum (ARB, LOCK_A, LOCK_B);
  - default WIDTH/DEPTH constants, shared with the SM datapath.
- Sub-module `sm_stack_core`:
  - contains the storage array and the count register;
  - inputs are push/pop strobes plus wdata;
  - outputs are rdata, count, full and empty;
  - carries no arbitration logic.
- The top level holds the FSM, the `rr` pointer, `lock_cnt`, port muxing and the response registers.

## Test plan
1. **Basic push/pop.** After rst, A pushes 0x00005 then 0x00003 and B pops twice. Required: count goes 1 then 2. B's two acks return rdata 0x00003 then 0x00005 with err=0. Then empty=1.
2. **Round-robin.** A and B both hold req high with PUSH for 4 cycles (A wdata 0x1, B wdata 0x2). Required: grants alternate A, B, A, B. Stack contents from bottom are 1, 2, 1, 2.
3. **Atomic lock.** Stack holds 7 then 4 (4 on top), count=2. A issues POP+lock, POP+lock, PUSH 0x0000B with lock=0, while B has req high with PUSH 0x9 throughout. Required: b_gnt=0 for those 3 cycles. B's push lands next. Final stack from bottom is 0xB, 0x9.
4. **Full and empty errors.** Fill with 8 pushes, then push 0xFFFFF. Required: err=1, count stays 8. Pop 8 times, then pop once more. Required: the final pop gives err=1, rdata=0.
5. **Lock timeout.** A asserts lock with req=1 and op NOP for 12 cycles while B requests PUSH. Required: b_gnt=0 for 9 cycles (8 A-grant cycles plus the timeout cycle with both gnts 0). lock_to pulses 1 in the cycle after the timeout cycle. B is granted on the next request.
6. **Reset mid-lock.** A is locked with count=3 and rst is asserted for 1 cycle. Required: count=0, empty=1, all acks 0. The next cycle is in ARB and B is granted immediately.
